// File: rtl/fir_mac_param_if.sv
// fir_mac_param_if: bundles the sample, coefficient and result handshakes of fir_mac_param.
interface fir_mac_param_if #(
   parameter int TAPS   = 4,
   parameter int DATA_W = 8,
   parameter int COEF_W = 8
);
   logic                      in_valid;
   logic                      in_ready;
   logic signed [DATA_W-1:0]  in_data;
   logic                      coef_we;
   logic [$clog2(TAPS)-1:0]   coef_addr;
   logic signed [COEF_W-1:0]  coef_data;
   logic                      out_valid;
   logic                      out_ready;
   logic signed [DATA_W-1:0]  out_data;
   logic                      busy;
   modport master (
      output in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
      input  in_ready, out_valid, out_data, busy
   );
   modport slave (
      input  in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/fir_mac_param.sv
// fir_mac_param: sample-serial FIR on one shared MAC; define FIR_SATURATE_EN to clamp instead of wrap the output.
module fir_mac_param #(
   parameter int TAPS   = 4,
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS),
   parameter int SHIFT  = 0
) (
   input logic            clk,
   input logic            global_reset,
   fir_mac_param_if.slave bus
);
   localparam int AW = $clog2(TAPS);
   localparam int KW = $clog2(TAPS + 1);
   localparam int PW = DATA_W + COEF_W;
`ifdef FIR_SATURATE_EN
   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;
`endif
   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
   state_t                    state_q;
   logic [KW-1:0]             k_q;
   logic [AW-1:0]             wr_ptr_q;
   logic signed [ACC_W-1:0]   acc_q;
   logic signed [ACC_W-1:0]   prod_q;
   logic signed [DATA_W-1:0]  hist_q [TAPS];
   logic signed [COEF_W-1:0]  coef_q [TAPS];
   logic                      in_ready_q;
   logic                      out_valid_q;
   logic signed [DATA_W-1:0]  out_data_q;
   logic                      busy_q;
   int                        rd_idx;
   logic [AW-1:0]             h_idx;
   logic [AW-1:0]             k_idx;
   logic signed [PW-1:0]      mul_d;
   logic signed [ACC_W-1:0]   prod_d;
   logic signed [ACC_W-1:0]   sum_d;
   logic signed [DATA_W-1:0]  y_d;
   logic                      coef_ok;
`ifdef FIR_SATURATE_EN
   logic signed [ACC_W-1:0]   res_d;
`endif
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.busy      = busy_q;
   assign coef_ok       = int'(bus.coef_addr) < TAPS;
   // Products are registered one stage ahead of the accumulator, so the last
   // MAC cycle folds the final product straight into the output register.
   always_comb begin
      rd_idx = int'(wr_ptr_q) - int'(k_q);
      rd_idx = (rd_idx < 0) ? rd_idx + TAPS : rd_idx;
      h_idx  = AW'(rd_idx);
      k_idx  = (k_q < KW'(TAPS)) ? k_q[AW-1:0] : '0;
      mul_d  = PW'(coef_q[k_idx]) * PW'(hist_q[h_idx]);
      prod_d = ACC_W'(mul_d);
      sum_d  = acc_q + prod_q;
`ifdef FIR_SATURATE_EN
      res_d  = sum_d >>> SHIFT;
      y_d    = (res_d > SAT_HI) ? SAT_HI[DATA_W-1:0] : (res_d < SAT_LO) ? SAT_LO[DATA_W-1:0] : res_d[DATA_W-1:0];
`else
      y_d    = DATA_W'(sum_d >>> SHIFT);
`endif
   end
   always_ff @(posedge clk) begin
      if (!global_reset) begin
         state_q     <= IDLE;
         k_q         <= '0;
         wr_ptr_q    <= '0;
         acc_q       <= '0;
         prod_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
         for (int i = 0; i < TAPS; i++) begin
            hist_q[i] <= '0;
            coef_q[i] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.coef_we && coef_ok) coef_q[bus.coef_addr] <= bus.coef_data;
               if (bus.in_valid) begin
                  hist_q[wr_ptr_q] <= bus.in_data;
                  acc_q            <= '0;
                  prod_q           <= '0;
                  k_q              <= '0;
                  in_ready_q       <= 1'b0;
                  busy_q           <= 1'b1;
                  state_q          <= MAC;
               end
            end
            MAC: begin
               acc_q  <= sum_d;
               prod_q <= prod_d;
               k_q    <= k_q + 1'b1;
               if (k_q == KW'(TAPS)) begin
                  out_data_q  <= y_d;
                  out_valid_q <= 1'b1;
                  state_q     <= OUT;
               end
            end
            OUT: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  wr_ptr_q    <= (wr_ptr_q == AW'(TAPS - 1)) ? '0 : wr_ptr_q + 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fir_mac_param.sv
// tb_fir_mac_param: directed scoreboard bench for fir_mac_param (TAPS=4, DATA_W=8, COEF_W=8, SHIFT=0).
module tb_fir_mac_param;
   localparam int TAPS = 4;
   logic clk = 1'b0;
   logic global_reset = 1'b0;
   always #5 clk = ~clk;
   fir_mac_param_if #(.TAPS(TAPS), .DATA_W(8), .COEF_W(8)) bus ();
   fir_mac_param #(.TAPS(TAPS), .DATA_W(8), .COEF_W(8), .SHIFT(0)) dut (
      .clk(clk),
      .global_reset(global_reset),
      .bus(bus)
   );
   int tests = 0;
   int fails = 0;
   logic signed [7:0] q_exp [$];
   int mh [TAPS];
   int mc [TAPS];
   int mptr = 0;
   time t_acc = 0;
   logic signed [7:0] last_y = '0;
   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   // Reference: direct convolution over the bench's own history copy.
   function automatic logic signed [7:0] model_y();
      int acc = 0;
      for (int k = 0; k < TAPS; k++) acc += mc[k] * mh[(mptr - k + TAPS) % TAPS];
`ifdef FIR_SATURATE_EN
      if (acc > 127) acc = 127;
      else if (acc < -128) acc = -128;
`endif
      return 8'(acc);
   endfunction
   task automatic model_clear();
      for (int i = 0; i < TAPS; i++) begin
         mh[i] = 0;
         mc[i] = 0;
      end
      mptr = 0;
      q_exp.delete();
   endtask
   task automatic do_reset();
      @(negedge clk);
      global_reset = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.coef_we = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_busy", bus.busy, 0);
      @(negedge clk);
      global_reset = 1'b1;
      model_clear();
   endtask
   task automatic write_coef(input logic [1:0] a, input logic signed [7:0] d, input bit taken);
      @(negedge clk);
      bus.coef_we = 1'b1;
      bus.coef_addr = a;
      bus.coef_data = d;
      @(posedge clk);
      #1;
      bus.coef_we = 1'b0;
      if (taken) mc[a] = d;
   endtask
   task automatic send(input logic signed [7:0] x);
      int n = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data = x;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      tests++;
      assert (n < 50) else begin
         fails++;
         $error("FAIL accept_timeout: observed %0d cycles expected <50", n);
      end
      @(posedge clk);
      t_acc = $time;
      mh[mptr] = x;
      q_exp.push_back(model_y());
      #1;
      bus.in_valid = 1'b0;
   endtask
   task automatic recv(input int stall);
      int n = 0;
      logic signed [7:0] d0;
      while (!bus.out_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("latency", int'(($time - 1 - t_acc) / 10), TAPS + 1);
      d0 = bus.out_data;
      repeat (stall) begin
         @(negedge clk);
         check("bp_valid", bus.out_valid, 1);
         check("bp_hold", bus.out_data, d0);
         check("bp_in_ready", bus.in_ready, 0);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      tests++;
      assert (q_exp.size() > 0) else begin
         fails++;
         $error("FAIL sb_empty: observed 0 entries expected >0");
      end
      if (q_exp.size() > 0) begin
         last_y = q_exp.pop_front();
         check("y", bus.out_data, last_y);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      mptr = (mptr + 1) % TAPS;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end
   initial begin
      logic signed [7:0] imp_x [5];
      logic signed [7:0] imp_y [5];
      logic signed [7:0] rc [4];
      imp_x = '{8'sd1, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
      imp_y = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd0};
      rc = '{-8'sd3, 8'sd5, -8'sd7, 8'sd2};
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.coef_we = 1'b0;
      bus.coef_addr = '0;
      bus.coef_data = '0;
      bus.out_ready = 1'b0;
      model_clear();
      do_reset();
      for (int i = 0; i < 4; i++) write_coef(2'(i), 8'(i + 1), 1'b1);
      for (int i = 0; i < 5; i++) begin
         send(imp_x[i]);
         recv(0);
         check("impulse_const", last_y, imp_y[i]);
      end
      send(8'sd7);
      bus.in_valid = 1'b1;
      bus.in_data = 8'sd5;
      recv(6);
      send(8'sd5);
      recv(0);
      do_reset();
      for (int i = 0; i < 4; i++) write_coef(2'(i), 8'(i + 1), 1'b1);
      send(8'sd1);
      write_coef(2'd0, 8'sd9, 1'b0);
      recv(0);
      check("busy_wr_y0", last_y, 1);
      send(8'sd1);
      recv(0);
      check("busy_wr_y1", last_y, 3);
      send(8'sd1);
      @(negedge clk);
      @(negedge clk);
      global_reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_busy", bus.busy, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      @(negedge clk);
      global_reset = 1'b1;
      model_clear();
      repeat (8) begin
         @(negedge clk);
         check("midrst_no_out", bus.out_valid, 0);
      end
      for (int i = 0; i < 4; i++) write_coef(2'(i), 8'(i + 1), 1'b1);
      for (int i = 0; i < 4; i++) begin
         send(imp_x[i]);
         recv(0);
         check("midrst_impulse", last_y, imp_y[i]);
      end
      do_reset();
      for (int i = 0; i < 4; i++) write_coef(2'(i), 8'sd127, 1'b1);
      for (int i = 0; i < 4; i++) begin
         send(8'sd127);
         recv(0);
      end
`ifdef FIR_SATURATE_EN
      check("overflow_sat", last_y, 127);
`else
      check("overflow_wrap", last_y, 4);
`endif
      do_reset();
      for (int i = 0; i < 4; i++) write_coef(2'(i), rc[i], 1'b1);
      for (int i = 0; i < 6; i++) begin
         send(8'($urandom_range(255)));
         recv(i % 3);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
